// File: rtl/modport_slave.sv
// rtl/modport_slave.sv - Wishbone B4 classic slave RAM with byte-lane writes
//
// Purpose:
//   Word-organised RAM of DEPTH words, DATA_WIDTH bits each, behind a flattened
//   Wishbone B4 classic slave port. Every strobed cycle gets exactly one
//   registered response (ack_o or err_o), one cycle after the request edge.
//   A held strobe therefore sees a 1-on / 1-off response cadence.
//
// Optional feature (macro MODPORT_SLAVE_ERR_EN):
//   defined     - a word index >= DEPTH terminates with err_o, no write and
//                 no change to dat_o.
//   not defined - err_o is tied 0, the word index wraps modulo DEPTH and every
//                 request is acknowledged.
//
// Parameters:
//   DATA_WIDTH   data bus width, a multiple of GRANULARITY
//   ADDR_WIDTH   byte address width
//   GRANULARITY  bits per sel lane, 8/16/32
//   DEPTH        number of words, a power of two (>= 2)
//
// Ports:
//   clk_i   in   clock, rising edge
//   rst_i   in   synchronous reset, active-high (memory is not cleared)
//   adr_i   in   byte address; byte-offset bits are ignored
//   dat_i   in   write data
//   we_i    in   1 = write, 0 = read
//   sel_i   in   lane enables for writes
//   stb_i   in   strobe
//   cyc_i   in   bus cycle in progress
//   dat_o   out  read data, valid with ack_o, holds last read value otherwise
//   ack_o   out  normal termination
//   err_o   out  error termination

module modport_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int GRANULARITY = 8,
    parameter int DEPTH       = 256
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [ADDR_WIDTH-1:0]               adr_i,
    input  logic [DATA_WIDTH-1:0]               dat_i,
    input  logic                                we_i,
    input  logic [DATA_WIDTH/GRANULARITY-1:0]   sel_i,
    input  logic                                stb_i,
    input  logic                                cyc_i,
    output logic [DATA_WIDTH-1:0]               dat_o,
    output logic                                ack_o,
    output logic                                err_o
);

    localparam int LANES    = DATA_WIDTH / GRANULARITY;
    localparam int OFF_BITS = $clog2(DATA_WIDTH / 8);
    localparam int IDX_BITS = $clog2(DEPTH);

    // Elaboration-time parameter sanity checks.
    if (!(GRANULARITY == 8 || GRANULARITY == 16 || GRANULARITY == 32)) begin : g_bad_granularity
        $fatal(1, "modport_slave: GRANULARITY must be 8, 16 or 32");
    end
    if ((DATA_WIDTH % GRANULARITY) != 0) begin : g_bad_width
        $fatal(1, "modport_slave: DATA_WIDTH must be a multiple of GRANULARITY");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "modport_slave: DEPTH must be a power of two >= 2");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  ack_q;
    logic                  ack_d;
    logic                  err_q;
    logic                  req;
    logic                  oor;
    logic [ADDR_WIDTH-1:0] word_adr;
    logic [IDX_BITS-1:0]   idx;

    assign word_adr = adr_i >> OFF_BITS;
    assign idx      = word_adr[IDX_BITS-1:0];

    // A response in flight blocks a new request, which gives the 1-on/1-off
    // cadence on a held strobe and guarantees one response per transfer.
    assign req   = cyc_i & stb_i & ~ack_q & ~err_q;
    assign ack_d = req & ~oor;

`ifdef MODPORT_SLAVE_ERR_EN
    logic unused_ok;

    // Any nonzero bit above the word index means the address is past DEPTH.
    assign oor       = |(word_adr >> IDX_BITS);
    assign unused_ok = ^adr_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= req & oor;
        end
    end

    assign err_o = err_q;
`else
    logic unused_ok;

    // Upper word-address bits are dropped, so out-of-range addresses alias.
    assign oor       = 1'b0;
    assign err_q     = 1'b0;
    assign unused_ok = ^{adr_i, word_adr};
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            // Only accepted reads load dat_o; writes and errors leave it alone.
            if (ack_d && !we_i) begin
                dat_q <= mem_q[idx];
            end
        end
    end

    // Storage has no reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i && ack_d && we_i) begin
            for (int l = 0; l < LANES; l++) begin
                if (sel_i[l]) begin
                    mem_q[idx][l*GRANULARITY +: GRANULARITY] <= dat_i[l*GRANULARITY +: GRANULARITY];
                end
            end
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;

endmodule

// File: tb/tb_modport_slave.sv
// tb/tb_modport_slave.sv - directed self-checking bench for modport_slave

module tb_modport_slave;

    logic        clk;
    logic        rst_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        stb_i;
    logic        cyc_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    modport_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .GRANULARITY(8),
        .DEPTH      (256)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .adr_i(adr_i),
        .dat_i(dat_i),
        .we_i (we_i),
        .sel_i(sel_i),
        .stb_i(stb_i),
        .cyc_i(cyc_i),
        .dat_o(dat_o),
        .ack_o(ack_o),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_bus();
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        sel_i = 4'h0;
        adr_i = 32'h0;
        dat_i = 32'h0;
    endtask

    // One single-beat transfer: drive at a falling edge, sample the response
    // at the next falling edge, then release the bus.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic ack, output logic err,
                        output logic [31:0] rd);
        @(negedge clk);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = we;
        adr_i = adr;
        dat_i = dat;
        sel_i = sel;
        @(negedge clk);
        ack = ack_o;
        err = err_o;
        rd  = dat_o;
        idle_bus();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle_bus();
        repeat (2) @(negedge clk);
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
        checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h want 00000000", dat_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_write_read();
        logic a, e;
        logic [31:0] rd;
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a, e, rd);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL wr_ack got %b want 1", a); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_keeps_dat got %h want 00000000", rd); end
        @(negedge clk);
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b want 0", ack_o); end
        xfer(1'b0, 32'h10, 32'h0, 4'h0, a, e, rd);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rd_ack got %b want 1", a); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_dat got %h want deadbeef", rd); end
        @(negedge clk);
        checks++; if (dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_dat_hold got %h want deadbeef", dat_o); end
    endtask

    task automatic test_partial_write();
        logic a, e;
        logic [31:0] rd;
        xfer(1'b1, 32'h10, 32'h11223344, 4'b0101, a, e, rd);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL part_ack got %b want 1", a); end
        xfer(1'b0, 32'h10, 32'h0, 4'h0, a, e, rd);
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL part_dat got %h want de22be44", rd); end
        xfer(1'b1, 32'h10, 32'h99999999, 4'h0, a, e, rd);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL sel0_ack got %b want 1", a); end
        xfer(1'b0, 32'h13, 32'h0, 4'h0, a, e, rd);
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL sel0_offset_dat got %h want de22be44", rd); end
    endtask

    task automatic test_back_to_back();
        logic a, e;
        logic [31:0] rd;
        xfer(1'b1, 32'h30, 32'h5A5A0F0F, 4'hF, a, e, rd);
        @(negedge clk);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b0;
        adr_i = 32'h30;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (ack_o !== 1'(i % 2)) begin errors++; $display("FAIL b2b_ack[%0d] got %b want %0d", i, ack_o, i % 2); end
            if (ack_o === 1'b1) begin
                checks++;
                if (dat_o !== 32'h5A5A0F0F) begin errors++; $display("FAIL b2b_dat[%0d] got %h want 5a5a0f0f", i, dat_o); end
            end
            checks++;
            if ((ack_o & err_o) !== 1'b0) begin errors++; $display("FAIL b2b_both[%0d] got ack=%b err=%b", i, ack_o, err_o); end
        end
        idle_bus();
    endtask

    task automatic test_cyc_stb_gating();
        logic a, e;
        logic [31:0] rd;
        @(negedge clk);
        cyc_i = 1'b0; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h10; dat_i = 32'hFFFFFFFF; sel_i = 4'hF;
        repeat (2) begin
            @(negedge clk);
            checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL nocyc_ack got %b want 0", ack_o); end
        end
        cyc_i = 1'b1; stb_i = 1'b0;
        @(negedge clk);
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL nostb_ack got %b want 0", ack_o); end
        // Read, then drop cyc_i while ack_o is high but keep stb_i.
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
        @(negedge clk);
        checks++; if (ack_o !== 1'b1) begin errors++; $display("FAIL cycdrop_ack got %b want 1", ack_o); end
        cyc_i = 1'b0;
        @(negedge clk);
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL cycdrop_ack_after got %b want 0", ack_o); end
        idle_bus();
        xfer(1'b0, 32'h10, 32'h0, 4'h0, a, e, rd);
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL gated_no_write got %h want de22be44", rd); end
    endtask

    task automatic test_out_of_range();
        logic a, e;
        logic [31:0] rd;
        logic [31:0] exp0;
        xfer(1'b1, 32'h000, 32'h01234567, 4'hF, a, e, rd);
        xfer(1'b0, 32'h000, 32'h0, 4'h0, a, e, rd);
        checks++; if (rd !== 32'h01234567) begin errors++; $display("FAIL oor_pre got %h want 01234567", rd); end
        xfer(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, a, e, rd);
`ifdef MODPORT_SLAVE_ERR_EN
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_err got %b want 1", e); end
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL oor_ack got %b want 0", a); end
        exp0 = 32'h01234567;
`else
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL oor_err got %b want 0", e); end
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL oor_ack got %b want 1", a); end
        exp0 = 32'hCAFEF00D;
`endif
        checks++; if (rd !== 32'h01234567) begin errors++; $display("FAIL oor_dat_hold got %h want 01234567", rd); end
        @(negedge clk);
        checks++; if ((ack_o | err_o) !== 1'b0) begin errors++; $display("FAIL oor_pulse got ack=%b err=%b want 0", ack_o, err_o); end
        xfer(1'b0, 32'h000, 32'h0, 4'h0, a, e, rd);
        checks++; if (rd !== exp0) begin errors++; $display("FAIL oor_alias got %h want %h", rd, exp0); end
    endtask

    task automatic test_reset_on_request();
        logic a, e;
        logic [31:0] rd;
        xfer(1'b1, 32'h20, 32'h0BADC0DE, 4'hF, a, e, rd);
        @(negedge clk);
        rst_i = 1'b1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h20; dat_i = 32'hA5A5A5A5; sel_i = 4'hF;
        @(negedge clk);
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL rstreq_ack got %b want 0", ack_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rstreq_err got %b want 0", err_o); end
        checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL rstreq_dat got %h want 00000000", dat_o); end
        rst_i = 1'b0;
        idle_bus();
        xfer(1'b0, 32'h20, 32'h0, 4'h0, a, e, rd);
        checks++; if (rd !== 32'h0BADC0DE) begin errors++; $display("FAIL rstreq_word got %h want 0badc0de", rd); end
    endtask

    initial begin
        rst_i = 1'b1;
        idle_bus();
        test_reset();
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_cyc_stb_gating();
        test_out_of_range();
        test_reset_on_request();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
